eae_sequencer: RTL and testbench

- CPU-side master of the eae_pins protocol. It accepts one decoded EAE operation from the CPU execute state machine and sequences it to completion.
- MUY/DVI: drives operands and a start pulse to the EAE arithmetic unit, waits for eae_fin, then captures the unit's registered results.
- SHL/ASR/LSR: executes shifts locally, one bit per cycle.
- Returns AC/MQ/L and a done pulse to the CPU register-write logic.

---
 rtl/eae_sequencer_pkg.sv | 32 +++
 rtl/eae_sequencer_shifter.sv | 58 +++++
 rtl/eae_sequencer.sv | 163 ++++++++++++++++
 tb/tb_eae_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/eae_sequencer_pkg.sv
// ============================================================================
//  Module      : eae_sequencer_pkg
//  Description : Shared types and constants for the EAE operation sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package eae_sequencer_pkg;

    localparam int WORD_W = 12;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        MUY = 3'd1,
        DVI = 3'd2,
        SHL = 3'd3,
        ASR = 3'd4,
        LSR = 3'd5
    } eae_op_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        SHIFT   = 3'd4,
        DONE    = 3'd5
    } eae_state_t;

endpackage

`default_nettype wire

// File: rtl/eae_sequencer_shifter.sv
// ============================================================================
//  Module      : eae_shifter
//  Description : 25-bit {L,AC,MQ} register with load, one-bit-per-cycle shift
//                and shift-count down-counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eae_shifter
    import eae_sequencer_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic                clock,
    input  logic                resetN,
    input  logic                i_load,
    input  logic [2*WORD_W:0]   i_load_data,
    input  logic [CNT_W:0]      i_load_cnt,
    input  logic                i_shift_en,
    input  eae_op_t             i_shift_op,
    output logic [2*WORD_W:0]   o_data,
    output logic                o_last
);

    logic [2*WORD_W:0] r_data;
    logic [CNT_W:0]    r_cnt;
    logic [2*WORD_W:0] w_shifted;

    always_comb begin
        w_shifted = r_data;
        case (i_shift_op)
            SHL:     w_shifted = {r_data[2*WORD_W-1:0], 1'b0};
            // L was already set to the sign at load; it stays put while shifting
            ASR:     w_shifted = {r_data[2*WORD_W], r_data[2*WORD_W-1], r_data[2*WORD_W-1:1]};
            LSR:     w_shifted = {2'b00, r_data[2*WORD_W-1:1]};
            default: w_shifted = r_data;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_data <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_data <= i_load_data;
            r_cnt  <= i_load_cnt;
        end else if (i_shift_en && (r_cnt != '0)) begin
            r_data <= w_shifted;
            r_cnt  <= r_cnt - (CNT_W+1)'(1);
        end
    end

    assign o_data = r_data;
    assign o_last = (r_cnt == (CNT_W+1)'(1));

endmodule

`default_nettype wire

// File: rtl/eae_sequencer.sv
// ============================================================================
//  Module      : eae_sequencer
//  Description : CPU-side master sequencing one EAE op (MUY/DVI via the EAE
//                unit, shifts locally) and returning AC/MQ/L with a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module eae_sequencer
    import eae_sequencer_pkg::*;
#(
    parameter int MAX_WAIT = 64,
    parameter int CNT_W    = 5
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              op_valid,
    input  logic [2:0]        op_code,
    input  logic [WORD_W-1:0] operand,
    input  logic [WORD_W-1:0] ac_in,
    input  logic [WORD_W-1:0] mq_in,
    input  logic              link_in,
    output logic              op_ready,
    output logic              eae_start,
    output logic [WORD_W-1:0] eae_ac,
    output logic [WORD_W-1:0] eae_mq,
    output logic [WORD_W-1:0] eae_mb,
    input  logic              eae_fin,
    input  logic [WORD_W-1:0] ac_mul,
    input  logic [WORD_W-1:0] mq_mul,
    input  logic [WORD_W-1:0] ac_dvi,
    input  logic [WORD_W-1:0] mq_dvi,
    input  logic              link_dvi,
    output logic [WORD_W-1:0] ac_out,
    output logic [WORD_W-1:0] mq_out,
    output logic              link_out,
    output logic              done,
    output logic              timeout_err
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    eae_state_t        r_state;
    eae_state_t        w_next;
    eae_op_t           r_op;
    eae_op_t           w_req_op;
    logic [WAIT_W-1:0] r_wait;
    logic              r_timeout;
    logic [WORD_W-1:0] r_eae_ac;
    logic [WORD_W-1:0] r_eae_mq;
    logic [WORD_W-1:0] r_eae_mb;

    logic              w_accept;
    logic              w_wait_expired;
    logic              w_load;
    logic              w_link_init;
    logic [2*WORD_W:0] w_load_data;
    logic [CNT_W:0]    w_load_cnt;
    logic [2*WORD_W:0] w_sh_data;
    logic              w_sh_last;

    assign w_req_op       = eae_op_t'(op_code);
    assign w_accept       = (r_state == IDLE) && op_valid;
    assign w_wait_expired = (r_wait == WAIT_W'(MAX_WAIT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (op_valid) begin
                    case (w_req_op)
                        MUY, DVI:      w_next = START;
                        SHL, ASR, LSR: w_next = SHIFT;
                        default:       w_next = DONE;
                    endcase
                end
            end
            START: w_next = WAIT;
            WAIT: begin
                if (eae_fin)             w_next = CAPTURE;
                else if (w_wait_expired) w_next = DONE;
            end
            CAPTURE: w_next = DONE;
            SHIFT:   if (w_sh_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_state   <= IDLE;
            r_op      <= NOP;
            r_wait    <= '0;
            r_timeout <= 1'b0;
            r_eae_ac  <= '0;
            r_eae_mq  <= '0;
            r_eae_mb  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op      <= w_req_op;
                r_timeout <= 1'b0;
                r_eae_ac  <= ac_in;
                r_eae_mq  <= mq_in;
                r_eae_mb  <= operand;
            end
            if (r_state == START) begin
                r_wait <= '0;
            end else if (r_state == WAIT) begin
                r_wait <= r_wait + WAIT_W'(1);
                if (!eae_fin && w_wait_expired) r_timeout <= 1'b1;
            end
        end
    end

    // The shifter register doubles as the result register for every op type
    always_comb begin
        w_link_init = link_in;
        if (w_req_op == ASR)      w_link_init = ac_in[WORD_W-1];
        else if (w_req_op == LSR) w_link_init = 1'b0;
    end

    assign w_load = w_accept || (r_state == CAPTURE);

    always_comb begin
        w_load_data = {w_link_init, ac_in, mq_in};
        w_load_cnt  = (CNT_W+1)'(operand[CNT_W-1:0]) + (CNT_W+1)'(1);
        if (r_state == CAPTURE) begin
            w_load_cnt = '0;
            if (r_op == DVI) w_load_data = {link_dvi, ac_dvi, mq_dvi};
            else             w_load_data = {1'b0, ac_mul, mq_mul};
        end
    end

    eae_shifter #(
        .CNT_W (CNT_W)
    ) u_shifter (
        .clock       (clock),
        .resetN      (resetN),
        .i_load      (w_load),
        .i_load_data (w_load_data),
        .i_load_cnt  (w_load_cnt),
        .i_shift_en  (r_state == SHIFT),
        .i_shift_op  (r_op),
        .o_data      (w_sh_data),
        .o_last      (w_sh_last)
    );

    assign op_ready    = (r_state == IDLE);
    assign eae_start   = (r_state == START);
    assign done        = (r_state == DONE);
    assign timeout_err = (r_state == DONE) && r_timeout;
    assign eae_ac      = r_eae_ac;
    assign eae_mq      = r_eae_mq;
    assign eae_mb      = r_eae_mb;
    assign link_out    = w_sh_data[2*WORD_W];
    assign ac_out      = w_sh_data[2*WORD_W-1:WORD_W];
    assign mq_out      = w_sh_data[WORD_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_eae_sequencer.sv
// ============================================================================
//  Module      : tb_eae_sequencer
//  Description : Directed self-checking bench for eae_sequencer with an EAE
//                unit stub.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eae_sequencer;
    import eae_sequencer_pkg::*;

    logic        clock    = 1'b0;
    logic        resetN   = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code  = 3'd0;
    logic [11:0] operand  = '0;
    logic [11:0] ac_in    = '0;
    logic [11:0] mq_in    = '0;
    logic        link_in  = 1'b0;
    logic        eae_fin  = 1'b0;
    logic [11:0] ac_mul   = '0;
    logic [11:0] mq_mul   = '0;
    logic [11:0] ac_dvi   = '0;
    logic [11:0] mq_dvi   = '0;
    logic        link_dvi = 1'b0;
    logic        op_ready, eae_start, link_out, done, timeout_err;
    logic [11:0] eae_ac, eae_mq, eae_mb, ac_out, mq_out;

    int errors    = 0;
    int checks    = 0;
    int stub_lat  = 0;
    int stub_cnt  = 0;
    int start_cnt = 0;
    int done_cnt  = 0;
    logic fin_pending = 1'b0;

    eae_sequencer #(.MAX_WAIT(64), .CNT_W(5)) dut (
        .clock(clock), .resetN(resetN), .op_valid(op_valid), .op_code(op_code),
        .operand(operand), .ac_in(ac_in), .mq_in(mq_in), .link_in(link_in),
        .op_ready(op_ready), .eae_start(eae_start), .eae_ac(eae_ac),
        .eae_mq(eae_mq), .eae_mb(eae_mb), .eae_fin(eae_fin), .ac_mul(ac_mul),
        .mq_mul(mq_mul), .ac_dvi(ac_dvi), .mq_dvi(mq_dvi), .link_dvi(link_dvi),
        .ac_out(ac_out), .mq_out(mq_out), .link_out(link_out), .done(done),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    // EAE unit stub: raises fin stub_lat cycles after start, registers results
    // on the edge that sees fin.
    always @(posedge clock) begin
        logic [23:0] prod;
        logic [23:0] dividend;
        #1;
        if (done === 1'b1)      done_cnt++;
        if (eae_start === 1'b1) start_cnt++;
        if (fin_pending) begin
            eae_fin     = 1'b0;
            fin_pending = 1'b0;
            prod   = 24'(eae_mq) * 24'(eae_mb) + 24'(eae_ac);
            ac_mul = prod[23:12];
            mq_mul = prod[11:0];
            if (eae_ac >= eae_mb) begin
                link_dvi = 1'b1;
                ac_dvi   = eae_ac;
                mq_dvi   = eae_mq;
            end else begin
                dividend = {eae_ac, eae_mq};
                link_dvi = 1'b0;
                mq_dvi   = 12'(dividend / 24'(eae_mb));
                ac_dvi   = 12'(dividend % 24'(eae_mb));
            end
        end
        if (stub_cnt == 1) begin
            eae_fin     = 1'b1;
            fin_pending = 1'b1;
            stub_cnt    = 0;
        end else if (stub_cnt > 1) begin
            stub_cnt--;
        end
        if (eae_start === 1'b1 && stub_lat > 0) stub_cnt = stub_lat;
    end

    task automatic issue(input eae_op_t op, input logic [11:0] opnd,
                         input logic [11:0] ac, input logic [11:0] mq, input logic l);
        int n = 0;
        while (op_ready !== 1'b1 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        checks++;
        if (op_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: op_ready=%b required 1", op_ready);
        end
        op_valid = 1'b1;
        op_code  = op;
        operand  = opnd;
        ac_in    = ac;
        mq_in    = mq;
        link_in  = l;
        @(posedge clock); #1;
        op_valid = 1'b0;
    endtask

    // cyc = clock edges after the accepting edge until done is seen
    task automatic wait_done(output int cyc, output logic seen);
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                cyc  = i;
                break;
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset;
        resetN = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks += 5;
        if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", op_ready); end
        if ({eae_start, done, timeout_err} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b want 000", {eae_start, done, timeout_err});
        end
        if ({ac_out, mq_out} !== 24'o0) begin
            errors++; $display("FAIL reset_out: got %o %o want 0 0", ac_out, mq_out);
        end
        if (link_out !== 1'b0) begin errors++; $display("FAIL reset_link: got %b want 0", link_out); end
        if ({eae_ac, eae_mq, eae_mb} !== 36'o0) begin
            errors++; $display("FAIL reset_eae_regs: got %o %o %o want 0", eae_ac, eae_mq, eae_mb);
        end
        resetN = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_muy;
        int cyc; logic seen;
        stub_lat  = 12;
        start_cnt = 0;
        issue(MUY, 12'o0005, 12'o0000, 12'o0003, 1'b0);
        wait_done(cyc, seen);
        checks += 6;
        if (!seen)               begin errors++; $display("FAIL muy_done: no done within bound"); end
        if (start_cnt !== 1)     begin errors++; $display("FAIL muy_start: %0d pulses want 1", start_cnt); end
        if (ac_out !== 12'o0000) begin errors++; $display("FAIL muy_ac: got %o want 0000", ac_out); end
        if (mq_out !== 12'o0017) begin errors++; $display("FAIL muy_mq: got %o want 0017", mq_out); end
        if (link_out !== 1'b0)   begin errors++; $display("FAIL muy_link: got %b want 0", link_out); end
        if (timeout_err !== 1'b0) begin errors++; $display("FAIL muy_tmo: got %b want 0", timeout_err); end
    endtask

    task automatic test_dvi;
        int cyc; logic seen;
        stub_lat = 5;
        issue(DVI, 12'o0007, 12'o0000, 12'o0144, 1'b0);
        wait_done(cyc, seen);
        checks += 4;
        if (!seen)               begin errors++; $display("FAIL dvi_done: no done within bound"); end
        if (mq_out !== 12'o0016) begin errors++; $display("FAIL dvi_mq: got %o want 0016", mq_out); end
        if (ac_out !== 12'o0002) begin errors++; $display("FAIL dvi_ac: got %o want 0002", ac_out); end
        if (link_out !== 1'b0)   begin errors++; $display("FAIL dvi_link: got %b want 0", link_out); end
        issue(DVI, 12'o0004, 12'o0010, 12'o0000, 1'b0);
        wait_done(cyc, seen);
        checks += 2;
        if (!seen)             begin errors++; $display("FAIL dvi_ovf_done: no done within bound"); end
        if (link_out !== 1'b1) begin errors++; $display("FAIL dvi_ovf_link: got %b want 1", link_out); end
    endtask

    task automatic test_shifts;
        int cyc; logic seen;
        issue(SHL, 12'd0, 12'o4000, 12'o0001, 1'b0);
        wait_done(cyc, seen);
        checks += 4;
        if (!seen || cyc != 1)   begin errors++; $display("FAIL shl_latency: got %0d want 1", cyc); end
        if (ac_out !== 12'o0000) begin errors++; $display("FAIL shl_ac: got %o want 0000", ac_out); end
        if (mq_out !== 12'o0002) begin errors++; $display("FAIL shl_mq: got %o want 0002", mq_out); end
        if (link_out !== 1'b1)   begin errors++; $display("FAIL shl_link: got %b want 1", link_out); end

        issue(ASR, 12'd2, 12'o7770, 12'o0000, 1'b0);
        wait_done(cyc, seen);
        checks += 4;
        if (!seen || cyc != 3)   begin errors++; $display("FAIL asr_latency: got %0d want 3", cyc); end
        if (ac_out !== 12'o7777) begin errors++; $display("FAIL asr_ac: got %o want 7777", ac_out); end
        if (mq_out !== 12'o0000) begin errors++; $display("FAIL asr_mq: got %o want 0000", mq_out); end
        if (link_out !== 1'b1)   begin errors++; $display("FAIL asr_link: got %b want 1", link_out); end

        issue(LSR, 12'd2, 12'o7770, 12'o0000, 1'b1);
        wait_done(cyc, seen);
        checks += 4;
        if (!seen || cyc != 3)   begin errors++; $display("FAIL lsr_latency: got %0d want 3", cyc); end
        if (ac_out !== 12'o0777) begin errors++; $display("FAIL lsr_ac: got %o want 0777", ac_out); end
        if (mq_out !== 12'o0000) begin errors++; $display("FAIL lsr_mq: got %o want 0000", mq_out); end
        if (link_out !== 1'b0)   begin errors++; $display("FAIL lsr_link: got %b want 0", link_out); end
    endtask

    task automatic test_nop_back_to_back;
        int cyc; logic seen;
        issue(NOP, 12'd0, 12'o1234, 12'o4321, 1'b1);
        wait_done(cyc, seen);
        checks += 3;
        if (!seen || cyc != 0) begin errors++; $display("FAIL nop_latency: got %0d want 0", cyc); end
        if ({link_out, ac_out, mq_out} !== {1'b1, 12'o1234, 12'o4321}) begin
            errors++; $display("FAIL nop_values: got %b %o %o want 1 1234 4321", link_out, ac_out, mq_out);
        end
        @(posedge clock); #1;
        if (op_ready !== 1'b1) begin errors++; $display("FAIL nop_ready_after: got %b want 1", op_ready); end
        // accept on the very cycle op_ready returns
        issue(SHL, 12'd1, 12'o0000, 12'o0001, 1'b0);
        wait_done(cyc, seen);
        checks += 1;
        if (!seen || cyc != 2 || mq_out !== 12'o0004) begin
            errors++; $display("FAIL b2b_shl: cyc %0d mq %o want 2 0004", cyc, mq_out);
        end
    endtask

    task automatic test_timeout;
        int cyc; logic seen;
        stub_lat = 0;
        issue(MUY, 12'o0005, 12'o1111, 12'o2222, 1'b1);
        wait_done(cyc, seen);
        checks += 3;
        if (!seen || cyc != 65) begin errors++; $display("FAIL tmo_latency: got %0d want 65", cyc); end
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_flag: got %b want 1", timeout_err); end
        if ({link_out, ac_out, mq_out} !== {1'b1, 12'o1111, 12'o2222}) begin
            errors++; $display("FAIL tmo_values: got %b %o %o want 1 1111 2222", link_out, ac_out, mq_out);
        end
    endtask

    task automatic test_reset_mid_wait;
        int cyc; logic seen;
        stub_lat = 20;
        issue(MUY, 12'o0005, 12'o0000, 12'o0003, 1'b0);
        repeat (5) @(posedge clock);
        #1;
        resetN = 1'b0;
        @(posedge clock); #1;
        checks += 2;
        if (op_ready !== 1'b1) begin errors++; $display("FAIL rst_wait_ready: got %b want 1", op_ready); end
        if ({eae_mb, ac_out} !== 24'o0) begin
            errors++; $display("FAIL rst_wait_regs: got %o %o want 0 0", eae_mb, ac_out);
        end
        resetN   = 1'b1;
        done_cnt = 0;
        repeat (30) @(posedge clock);
        #1;
        checks += 2;
        if (done_cnt !== 0)    begin errors++; $display("FAIL rst_wait_nodone: got %0d pulses want 0", done_cnt); end
        if (op_ready !== 1'b1) begin errors++; $display("FAIL rst_wait_idle: got %b want 1", op_ready); end
        stub_lat = 4;
        issue(MUY, 12'o0006, 12'o0000, 12'o0007, 1'b0);
        wait_done(cyc, seen);
        checks += 2;
        if (!seen || timeout_err !== 1'b0) begin
            errors++; $display("FAIL rst_next_done: seen %b tmo %b want 1 0", seen, timeout_err);
        end
        if ({ac_out, mq_out} !== {12'o0000, 12'o0052}) begin
            errors++; $display("FAIL rst_next_result: got %o %o want 0000 0052", ac_out, mq_out);
        end
    endtask

    initial begin
        test_reset();
        test_muy();
        test_dvi();
        test_shifts();
        test_nop_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
